// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream (16-bit word count header, then payload words)
// into 32-bit instruction-memory writes while stalling the core. Optional trailer: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              cpu_stall_o,
  output logic              done_o,
  output logic              error_o,
  output logic [15:0]       words_loaded_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_LO, S_HDR_HI, S_LOAD, S_DONE, S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_e;

  // State entered once the payload has been fully consumed.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e S_END = S_CHK;
`else
  localparam state_e S_END = S_DONE;
`endif

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_e            state_q, state_d;
  logic [15:0]       n_q;
  logic [1:0]        idx_q;
  logic [23:0]       buf_q;
  logic [15:0]       words_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic        start_ok, xfer, word_end, last_word;
  logic [15:0] hdr_n;

  assign start_ok  = load_start_i & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR));
  assign xfer      = byte_valid_i & byte_ready_o;
  assign hdr_n     = {byte_data_i, n_q[7:0]};
  assign word_end  = xfer & (state_q == S_LOAD) & (idx_q == 2'd3);
  assign last_word = ((words_q + 16'd1) == n_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start_ok) state_d = S_HDR_LO;
      S_HDR_LO: if (xfer) state_d = S_HDR_HI;
      S_HDR_HI: begin
        if (xfer) begin
          if (hdr_n == 16'd0)                 state_d = S_END;
          else if ({1'b0, hdr_n} > DEPTH_L)   state_d = S_ERR;
          else                                state_d = S_LOAD;
        end
      end
      S_LOAD: if (word_end && last_word) state_d = S_END;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: if (xfer) state_d = (byte_data_i == csum_q) ? S_DONE : S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready_o = 1'b0;
    cpu_stall_o  = 1'b0;
    done_o       = 1'b0;
    error_o      = 1'b0;
    case (state_q)
      S_HDR_LO, S_HDR_HI, S_LOAD: begin
        byte_ready_o = 1'b1;
        cpu_stall_o  = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        byte_ready_o = 1'b1;
        cpu_stall_o  = 1'b1;
      end
`endif
      S_DONE:  done_o  = 1'b1;
      S_ERR:   error_o = 1'b1;
      default: ;
    endcase
  end

  // The write is registered so mem_we lands one cycle after the 4th byte; lane 0 of the
  // next word can be accepted in that same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_q     <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      if (start_ok) begin
        words_q <= '0;
        idx_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q  <= '0;
`endif
      end
      if (xfer) begin
        case (state_q)
          S_HDR_LO: n_q[7:0]  <= byte_data_i;
          S_HDR_HI: n_q[15:8] <= byte_data_i;
          S_LOAD: begin
            idx_q <= idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ byte_data_i;
`endif
            case (idx_q)
              2'd0: buf_q[7:0]   <= byte_data_i;
              2'd1: buf_q[15:8]  <= byte_data_i;
              2'd2: buf_q[23:16] <= byte_data_i;
              default: begin
                we_q    <= 1'b1;
                addr_q  <= ADDR_W'(words_q);
                wdata_q <= {byte_data_i, buf_q};
                words_q <= words_q + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_we_o       = we_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign words_loaded_o = words_q;

endmodule
